// File: rtl/tsmap_rd_arbiter.sv
// Round-robin arbiter sharing one TS-map SRAM read port among NumCh requesters.
// A grant relocates the channel's word index into the SRAM address space and
// bounds-checks it. A {valid, ch_id, err} shift register, RdLatency deep,
// returns each response in grant order to the channel that asked for it.
// The SRAM word arrives in the same cycle as the matching pipeline entry.
// The response data is therefore steered straight from tsmap_rdata_i while
// rvalid is high. Registers keep the last data/err value between responses.
module tsmap_rd_arbiter #(
  parameter int          NumCh      = 2,
  parameter logic [31:0] TSMapBase  = 32'h200f_e000,
  parameter logic [31:0] DRamBase   = 32'h200f_0000,
  parameter int          TSMapWords = 512,
  parameter int          ChAddrW    = 14,
  parameter int          MemAddrW   = 16,
  parameter int          RdLatency  = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumCh-1:0]         ch_req_i,
  input  logic [NumCh*ChAddrW-1:0] ch_addr_i,
  output logic [NumCh-1:0]         ch_gnt_o,
  output logic [NumCh-1:0]         ch_rvalid_o,
  output logic                     ch_rerr_o,
  output logic [31:0]              ch_rdata_o,
  output logic                     tsmap_cs_o,
  output logic [MemAddrW-1:0]      tsmap_addr_o,
  input  logic [31:0]              tsmap_rdata_i
);

  localparam int          ChIdW    = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam logic [31:0] Offset   = (TSMapBase - DRamBase) >> 2;
  localparam longint      LastWord = longint'(Offset) + longint'(TSMapWords) - 1;

  // Reject parameter sets that would place the map outside the SRAM or misalign it
  if (TSMapBase < DRamBase || TSMapBase[1:0] != 2'b00 ||
      !(RdLatency == 1 || RdLatency == 2) ||
      LastWord >= (longint'(1) << MemAddrW) ||
      NumCh < 1 || NumCh > 8) begin : g_param_check
    $error("tsmap_rd_arbiter: illegal parameter combination");
  end

  logic [ChAddrW-1:0] ch_addr [NumCh];
  logic [ChIdW-1:0]   rr_ptr;
  logic [ChIdW-1:0]   gnt_id;
  logic               found;
  int                 cand;
  logic [ChAddrW-1:0] gnt_idx;
  logic               in_range;

  logic               pipe_valid [RdLatency];
  logic [ChIdW-1:0]   pipe_ch    [RdLatency];
  logic               pipe_err   [RdLatency];
  logic               resp_valid;
  logic [ChIdW-1:0]   resp_ch;
  logic               resp_err;
  logic [31:0]        resp_data;
  logic [31:0]        rdata_hold;
  logic               err_hold;

  // Split the flat address bus into per-channel word indices
  for (genvar gi = 0; gi < NumCh; gi++) begin : g_addr_split
    assign ch_addr[gi] = ch_addr_i[gi*ChAddrW +: ChAddrW];
  end

  // Round-robin search from rr_ptr; the first requester wins and reset blocks any grant
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = 0;
    for (int k = 0; k < NumCh; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NumCh) cand = cand - NumCh;
      if (!found && ch_req_i[cand]) begin
        found  = 1'b1;
        gnt_id = ChIdW'(cand);
      end
    end
    if (rst_i) found = 1'b0;
  end

  assign gnt_idx  = ch_addr[gnt_id];
  assign in_range = 32'(gnt_idx) < 32'(TSMapWords);

  // Out-of-range grants still get a response slot, but they never touch the SRAM
  assign tsmap_cs_o   = found && in_range;
  assign tsmap_addr_o = tsmap_cs_o ? MemAddrW'(Offset + 32'(gnt_idx)) : '0;

  for (genvar gi = 0; gi < NumCh; gi++) begin : g_onehot
    assign ch_gnt_o[gi]    = found && (gnt_id == ChIdW'(gi));
    assign ch_rvalid_o[gi] = resp_valid && (resp_ch == ChIdW'(gi));
  end

  // Advance the round-robin pointer past the winner; hold it when nobody is granted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (gnt_id == ChIdW'(NumCh - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Response tag pipeline, matched to the SRAM read latency
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < RdLatency; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_ch[s]    <= '0;
        pipe_err[s]   <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= found;
      pipe_ch[0]    <= gnt_id;
      pipe_err[0]   <= !in_range;
      for (int s = 1; s < RdLatency; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_ch[s]    <= pipe_ch[s-1];
        pipe_err[s]   <= pipe_err[s-1];
      end
    end
  end

  assign resp_valid = pipe_valid[RdLatency-1];
  assign resp_ch    = pipe_ch[RdLatency-1];
  assign resp_err   = pipe_err[RdLatency-1];
  assign resp_data  = resp_err ? 32'h0 : tsmap_rdata_i;

  // Keep the last response's data/err visible between responses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_hold <= 32'h0;
      err_hold   <= 1'b0;
    end else if (resp_valid) begin
      rdata_hold <= resp_data;
      err_hold   <= resp_err;
    end
  end

  assign ch_rdata_o = resp_valid ? resp_data : rdata_hold;
  assign ch_rerr_o  = resp_valid ? resp_err  : err_hold;

endmodule

// File: tb/tb_tsmap_rd_arbiter.sv
// Randomised bench for tsmap_rd_arbiter: two instances (read latency 1 and 2,
// three channels) share one request stream. Each is checked every cycle
// against a reference model of the arbitration, relocation and response rules.
module tb_tsmap_rd_arbiter;

  localparam int N  = 3;
  localparam int AW = 14;
  localparam int MW = 16;
  localparam int NDIR = 20;

  // directed prologue: req mask, reset, and per-channel indices per cycle
  localparam logic [2:0] T_REQ [NDIR] = '{3'b001, 3'b010, 3'b001, 3'b010,
    3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b001, 3'b001, 3'b001,
    3'b011, 3'b001, 3'b001, 3'b011, 3'b011, 3'b011, 3'b010};
  localparam int T_RST [NDIR] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,0,0};
  localparam int T_I0 [NDIR] = '{5,0,0,0,100,100,100,100,100,100,7,7,7,7,7,20,1,1,1,0};
  localparam int T_I1 [NDIR] = '{0,512,0,511,200,200,200,200,200,200,0,0,0,9,0,0,2,2,2,2};
  localparam int T_I2 [NDIR] = '{0,0,0,0,300,300,300,300,300,300,0,0,0,0,0,0,0,0,0,0};

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;

  logic [N-1:0]    d_gnt    [2];
  logic [N-1:0]    d_rvalid [2];
  logic            d_rerr   [2];
  logic [31:0]     d_rdata  [2];
  logic            d_cs     [2];
  logic [MW-1:0]   d_maddr  [2];
  logic [31:0]     d_srdata [2];

  always #5 clk = ~clk;

  tsmap_rd_arbiter #(.NumCh(N), .RdLatency(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .ch_req_i(req), .ch_addr_i(addr),
    .ch_gnt_o(d_gnt[0]), .ch_rvalid_o(d_rvalid[0]), .ch_rerr_o(d_rerr[0]),
    .ch_rdata_o(d_rdata[0]), .tsmap_cs_o(d_cs[0]), .tsmap_addr_o(d_maddr[0]),
    .tsmap_rdata_i(d_srdata[0])
  );

  tsmap_rd_arbiter #(.NumCh(N), .RdLatency(2)) u_dut_l2 (
    .clk_i(clk), .rst_i(rst), .ch_req_i(req), .ch_addr_i(addr),
    .ch_gnt_o(d_gnt[1]), .ch_rvalid_o(d_rvalid[1]), .ch_rerr_o(d_rerr[1]),
    .ch_rdata_o(d_rdata[1]), .tsmap_cs_o(d_cs[1]), .tsmap_addr_o(d_maddr[1]),
    .tsmap_rdata_i(d_srdata[1])
  );

  // reference model state
  int            ptr;
  logic [N-1:0]  req_state;
  logic [AW-1:0] idx_state [N];
  logic          due_v [2][3];
  int            due_c [2][3];
  logic          due_e [2][3];
  logic [31:0]   due_d [2][3];
  logic [31:0]   last_d [2];
  logic          last_e [2];
  logic          hist_cs [2][2];
  logic [MW-1:0] hist_a  [2][2];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL cyc=%0d %s: got %0h, expected %0h", cyc, tag, obs, exp);
  endtask

  function automatic logic [31:0] sram_word(input int d, input logic [MW-1:0] a);
    return {a, ~a} ^ ((d == 0) ? 32'hdead_beef : 32'h1234_5678);
  endfunction

  function automatic logic [AW-1:0] pick_idx();
    case ($urandom_range(0, 7))
      0:       return 14'd0;
      1:       return 14'd511;
      2:       return 14'd512;
      3:       return 14'h3fff;
      4:       return 14'd1;
      default: return AW'($urandom_range(0, 599));
    endcase
  endfunction

  task automatic clear_model();
    ptr = 0;
    for (int d = 0; d < 2; d++) begin
      last_d[d] = 32'h0;
      last_e[d] = 1'b0;
      for (int j = 0; j < 3; j++) begin
        due_v[d][j] = 1'b0; due_c[d][j] = 0; due_e[d][j] = 1'b0; due_d[d][j] = 32'h0;
      end
      for (int j = 0; j < 2; j++) begin
        hist_cs[d][j] = 1'b0; hist_a[d][j] = '0;
      end
    end
  endtask

  // one clock cycle: drive at the negedge, check 1 time unit later, advance the model
  task automatic do_cycle(input logic rst_now);
    int            win;
    logic [AW-1:0] idx;
    logic          inr;
    logic          ecs;
    logic [MW-1:0] eaddr;
    logic [N-1:0]  exp_rv;
    rst = rst_now;
    req = req_state;
    for (int c = 0; c < N; c++) addr[c*AW +: AW] = idx_state[c];
    for (int d = 0; d < 2; d++)
      d_srdata[d] = hist_cs[d][d] ? sram_word(d, hist_a[d][d]) : $urandom;
    #1;
    win = -1;
    if (rst_now) clear_model();
    else begin
      for (int k = 0; k < N; k++)
        if (win < 0 && req_state[(ptr + k) % N]) win = (ptr + k) % N;
    end
    idx   = (win >= 0) ? idx_state[win] : '0;
    inr   = (int'(idx) < 512);
    ecs   = (win >= 0) && inr;
    eaddr = ecs ? MW'(32'h3800 + int'(idx)) : '0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("L%0d gnt", d+1), 32'(d_gnt[d]), (win >= 0) ? (32'd1 << win) : 32'd0);
      check($sformatf("L%0d cs", d+1), 32'(d_cs[d]), 32'(ecs));
      check($sformatf("L%0d addr", d+1), 32'(d_maddr[d]), 32'(eaddr));
      exp_rv = '0;
      if (due_v[d][0]) begin
        exp_rv    = N'(1 << due_c[d][0]);
        last_e[d] = due_e[d][0];
        last_d[d] = due_d[d][0];
      end
      check($sformatf("L%0d rvalid", d+1), 32'(d_rvalid[d]), 32'(exp_rv));
      check($sformatf("L%0d rerr", d+1), 32'(d_rerr[d]), 32'(last_e[d]));
      check($sformatf("L%0d rdata", d+1), d_rdata[d], last_d[d]);
      for (int j = 0; j < 2; j++) begin
        due_v[d][j] = due_v[d][j+1]; due_c[d][j] = due_c[d][j+1];
        due_e[d][j] = due_e[d][j+1]; due_d[d][j] = due_d[d][j+1];
      end
      due_v[d][2] = 1'b0;
      if (win >= 0) begin
        due_v[d][d] = 1'b1;
        due_c[d][d] = win;
        due_e[d][d] = !inr;
        due_d[d][d] = inr ? sram_word(d, eaddr) : 32'h0;
      end
      hist_cs[d][1] = hist_cs[d][0]; hist_a[d][1] = hist_a[d][0];
      hist_cs[d][0] = d_cs[d];       hist_a[d][0] = d_maddr[d];
    end
    if (win >= 0) begin
      req_state[win] = 1'b0;
      ptr = (win + 1) % N;
    end
    cyc++;
    @(negedge clk);
  endtask

  // stimulus: power-on reset, directed prologue, then randomised traffic with occasional resets
  initial begin
    int rst_left;
    rst = 1'b1;
    req = '0;
    addr = '0;
    d_srdata[0] = 32'h0;
    d_srdata[1] = 32'h0;
    req_state = '0;
    for (int c = 0; c < N; c++) idx_state[c] = '0;
    clear_model();
    @(negedge clk);
    do_cycle(1'b1);
    do_cycle(1'b1);
    for (int k = 0; k < NDIR; k++) begin
      req_state    = T_REQ[k];
      idx_state[0] = AW'(T_I0[k]);
      idx_state[1] = AW'(T_I1[k]);
      idx_state[2] = AW'(T_I2[k]);
      do_cycle(T_RST[k] != 0);
    end
    rst_left = 0;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < N; c++)
        if (!req_state[c] && $urandom_range(0, 1) == 1) begin
          req_state[c] = 1'b1;
          idx_state[c] = pick_idx();
        end
      if (rst_left > 0) begin
        rst_left--;
        do_cycle(1'b1);
      end else if ($urandom_range(0, 59) == 0) begin
        rst_left = 1;
        do_cycle(1'b1);
      end else begin
        do_cycle(1'b0);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
